// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_DATA_W = 32;

  // addi x0, x0, 0 -- the canonical bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  // IF/ID payload at the default widths
  typedef struct packed {
    logic [FETCH_DATA_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_ADDR_W-1:0] pcplus4;
    logic                    valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Control, PC-mux and decode-side signals of the fetch stage.
interface fetch_stage_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic                     trigger;
  logic                     stallf;
  logic                     stalld;
  logic                     flushd;
  logic [ADDRESS_WIDTH-1:0] next_pc;
  logic [ADDRESS_WIDTH-1:0] pcplus4_f;
  logic [DATA_WIDTH-1:0]    instr_f;
  logic [ADDRESS_WIDTH-1:0] pc_f;
  logic [DATA_WIDTH-1:0]    instr_d;
  logic [ADDRESS_WIDTH-1:0] pc_d;
  logic [ADDRESS_WIDTH-1:0] pcplus4_d;
  logic                     valid_d;
  logic                     running;
  logic [DATA_WIDTH-1:0]    fetch_count;

  modport master (
    output trigger, stallf, stalld, flushd, next_pc, pcplus4_f, instr_f,
    input  pc_f, instr_d, pc_d, pcplus4_d, valid_d, running, fetch_count
  );

  modport slave (
    input  trigger, stallf, stalld, flushd, next_pc, pcplus4_f, instr_f,
    output pc_f, instr_d, pc_d, pcplus4_d, valid_d, running, fetch_count
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load; flush inserts a NOP bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     stall,
  input  logic [DATA_WIDTH-1:0]    instr_in,
  input  logic [ADDRESS_WIDTH-1:0] pc_in,
  input  logic [ADDRESS_WIDTH-1:0] pcplus4_in,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic [ADDRESS_WIDTH-1:0] pcplus4,
  output logic                     valid
);

  localparam logic [DATA_WIDTH-1:0] BUBBLE_INSTR = DATA_WIDTH'(NOP_INSTR);

  // Pipeline register update with bubble insertion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr   <= BUBBLE_INSTR;
      pc      <= '0;
      pcplus4 <= '0;
      valid   <= 1'b0;
    end else if (flush) begin
      instr   <= BUBBLE_INSTR;
      pc      <= '0;
      pcplus4 <= '0;
      valid   <= 1'b0;
    end else if (!stall) begin
      instr   <= instr_in;
      pc      <= pc_in;
      pcplus4 <= pcplus4_in;
      valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: run/idle FSM, architectural PC, fetch counter and IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.slave  bus
);

  fetch_state_t             state_q, state_d;
  logic                     run_act;
  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0]    count_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; an edge only does real work when already in RUN with trigger still high
  always_comb begin
    state_d = state_q;
    run_act = 1'b0;
    case (state_q)
      IDLE: if (bus.trigger) state_d = RUN;
      RUN: begin
        if (!bus.trigger) state_d = IDLE;
        else              run_act = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // PC register: cleared outside active RUN, held on stallf
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pc_q <= '0;
    else if (!run_act) pc_q <= '0;
    else if (!bus.stallf) pc_q <= bus.next_pc;
  end

  // Fetch counter: one per PC advance, wraps silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          count_q <= '0;
    else if (run_act && !bus.stallf)  count_q <= count_q + DATA_WIDTH'(1);
  end

  if_id_reg #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.flushd || !run_act),
    .stall      (bus.stalld),
    .instr_in   (bus.instr_f),
    .pc_in      (pc_q),
    .pcplus4_in (bus.pcplus4_f),
    .instr      (bus.instr_d),
    .pc         (bus.pc_d),
    .pcplus4    (bus.pcplus4_d),
    .valid      (bus.valid_d)
  );

  assign bus.pc_f        = pc_q;
  assign bus.fetch_count = count_q;
  assign bus.running     = (state_q == RUN);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus reset and wrap sequences.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();
  fetch_stage_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(8))  bus8 ();

  fetch_stage #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  fetch_stage #(.ADDRESS_WIDTH(32), .DATA_WIDTH(8)) dut8 (
    .clk (clk), .rst (rst), .bus (bus8)
  );

  typedef struct {
    logic        trig, sf, sd, fd;
    logic [31:0] npc, p4, ins;
    logic [31:0] e_pc;
    if_id_t      e_ifid;
    logic        e_run;
    logic [31:0] e_cnt;
  } vec_t;

  int total = 0;
  int bad   = 0;
  string tag;
  vec_t v [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s %s: got %h want %h", tag, name, act, exp);
    end
  endtask

  task automatic chk_all(input logic [31:0] e_pc, input if_id_t e, input logic e_run,
                         input logic [31:0] e_cnt);
    chk("pc_f", bus.pc_f, e_pc);
    chk("instr_d", bus.instr_d, e.instr);
    chk("pc_d", bus.pc_d, e.pc);
    chk("pcplus4_d", bus.pcplus4_d, e.pcplus4);
    chk("valid_d", 32'(bus.valid_d), 32'(e.valid));
    chk("running", 32'(bus.running), 32'(e_run));
    chk("fetch_count", bus.fetch_count, e_cnt);
  endtask

  function automatic if_id_t ifid(input logic [31:0] i, input logic [31:0] p,
                                  input logic [31:0] p4, input logic vl);
    if_id_t r;
    r.instr = i; r.pc = p; r.pcplus4 = p4; r.valid = vl;
    return r;
  endfunction

  function automatic vec_t mk(input logic t, input logic sf, input logic sd, input logic fd,
                              input logic [31:0] npc, input logic [31:0] p4,
                              input logic [31:0] ins, input logic [31:0] e_pc,
                              input if_id_t e, input logic e_run, input logic [31:0] e_cnt);
    vec_t r;
    r.trig = t; r.sf = sf; r.sd = sd; r.fd = fd;
    r.npc = npc; r.p4 = p4; r.ins = ins;
    r.e_pc = e_pc; r.e_ifid = e; r.e_run = e_run; r.e_cnt = e_cnt;
    return r;
  endfunction

  initial begin
    if_id_t bub;
    bub = ifid(NOP_INSTR, 32'h0, 32'h0, 1'b0);

    //        trg sf sd fd  next_pc        pcplus4_f     instr_f        exp pc_f
    v[0]  = mk(1, 0, 0, 0, 32'h4,         32'h4,        32'h0050_0093, 32'h0,
               bub, 1, 0);
    v[1]  = mk(1, 0, 0, 0, 32'h4,         32'h4,        32'h0050_0093, 32'h4,
               ifid(32'h0050_0093, 32'h0, 32'h4, 1), 1, 1);
    v[2]  = mk(1, 1, 1, 0, 32'h8,         32'h8,        32'h0010_0113, 32'h4,
               ifid(32'h0050_0093, 32'h0, 32'h4, 1), 1, 1);
    v[3]  = mk(1, 1, 1, 0, 32'h8,         32'h8,        32'h0010_0113, 32'h4,
               ifid(32'h0050_0093, 32'h0, 32'h4, 1), 1, 1);
    v[4]  = mk(1, 1, 1, 0, 32'h8,         32'h8,        32'h0010_0113, 32'h4,
               ifid(32'h0050_0093, 32'h0, 32'h4, 1), 1, 1);
    v[5]  = mk(1, 0, 0, 0, 32'h8,         32'h8,        32'h0010_0113, 32'h8,
               ifid(32'h0010_0113, 32'h4, 32'h8, 1), 1, 2);
    v[6]  = mk(1, 0, 1, 1, 32'hC,         32'hC,        32'h0020_0193, 32'hC,
               bub, 1, 3);
    v[7]  = mk(1, 0, 0, 0, 32'h10,        32'h10,       32'h0030_0213, 32'h10,
               ifid(32'h0030_0213, 32'hC, 32'h10, 1), 1, 4);
    v[8]  = mk(1, 0, 1, 0, 32'h100,       32'h14,       32'hDEAD_BEEF, 32'h100,
               ifid(32'h0030_0213, 32'hC, 32'h10, 1), 1, 5);
    v[9]  = mk(1, 0, 0, 0, 32'hFFFF_FFFF, 32'h104,      32'h0040_0293, 32'hFFFF_FFFF,
               ifid(32'h0040_0293, 32'h100, 32'h104, 1), 1, 6);
    v[10] = mk(0, 0, 1, 0, 32'h200,       32'h204,      32'h0000_0001, 32'h0,
               bub, 0, 6);
    v[11] = mk(0, 0, 0, 0, 32'h200,       32'h204,      32'h0000_0001, 32'h0,
               bub, 0, 6);
    v[12] = mk(1, 0, 0, 0, 32'h40,        32'h4,        32'h0000_0001, 32'h0,
               bub, 1, 6);
    v[13] = mk(1, 1, 0, 0, 32'h40,        32'h4,        32'h0060_0313, 32'h0,
               ifid(32'h0060_0313, 32'h0, 32'h4, 1), 1, 6);
    v[14] = mk(1, 0, 0, 0, 32'h40,        32'h4,        32'h0070_0393, 32'h40,
               ifid(32'h0070_0393, 32'h0, 32'h4, 1), 1, 7);

    rst = 1'b1;
    bus.trigger = 0; bus.stallf = 0; bus.stalld = 0; bus.flushd = 0;
    bus.next_pc = '0; bus.pcplus4_f = '0; bus.instr_f = '0;
    bus8.trigger = 0; bus8.stallf = 0; bus8.stalld = 0; bus8.flushd = 0;
    bus8.next_pc = '0; bus8.pcplus4_f = '0; bus8.instr_f = '0;

    // Reset values before any clock edge
    #2;
    tag = "reset";
    chk_all(32'h0, bub, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 15; i++) begin
      bus.trigger = v[i].trig; bus.stallf = v[i].sf;
      bus.stalld = v[i].sd; bus.flushd = v[i].fd;
      bus.next_pc = v[i].npc; bus.pcplus4_f = v[i].p4; bus.instr_f = v[i].ins;
      @(posedge clk);
      #1;
      tag = $sformatf("vec%0d", i);
      chk_all(v[i].e_pc, v[i].e_ifid, v[i].e_run, v[i].e_cnt);
    end

    // Asynchronous reset between edges mid-RUN
    tag = "async_rst";
    chk("pre_valid", 32'(bus.valid_d), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk_all(32'h0, bub, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    tag = "rst_hold";
    chk_all(32'h0, bub, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.trigger = 1; bus.stallf = 0; bus.stalld = 0; bus.flushd = 0;
    bus.next_pc = 32'h4; bus.pcplus4_f = 32'h4; bus.instr_f = 32'h0050_0093;
    @(posedge clk);
    #1;
    tag = "resume_idle";
    chk_all(32'h0, bub, 1'b1, 32'h0);
    @(posedge clk);
    #1;
    tag = "resume_run";
    chk_all(32'h4, ifid(32'h0050_0093, 32'h0, 32'h4, 1), 1'b1, 32'h1);

    // Counter wrap on the narrow-count instance
    bus8.trigger = 1;
    @(posedge clk);
    #1;
    tag = "wrap_start";
    chk("fetch_count8", 32'(bus8.fetch_count), 32'h0);
    chk("running8", 32'(bus8.running), 32'h1);
    repeat (255) @(posedge clk);
    #1;
    tag = "wrap_max";
    chk("fetch_count8", 32'(bus8.fetch_count), 32'hFF);
    @(posedge clk);
    #1;
    tag = "wrap_zero";
    chk("fetch_count8", 32'(bus8.fetch_count), 32'h0);
    chk("bubble8", 32'(bus8.instr_d), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

●
